// File: rtl/stage_frame_reader.sv
// Frame-boundary snapshot and playfield cell scanner feeding the framebuffer writer.
// Optional cell_border output is enabled by defining STAGE_FRAME_BORDER_EN.
module stage_frame_reader #(
  parameter int unsigned GRID_W = 40,
  parameter int unsigned GRID_H = 30,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       rstage,
  input  logic              isDrawing,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [5:0]        cell_x,
  output logic [4:0]        cell_y,
  output logic [31:0]       cell_stage,
  output logic              cell_last,
  output logic              frame_busy,
  output logic [CNT_W-1:0]  frame_count,
  output logic              overrun
`ifdef STAGE_FRAME_BORDER_EN
  ,
  output logic              cell_border
`endif
);

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_e;

  localparam logic [5:0] X_LAST = 6'(GRID_W - 1);
  localparam logic [4:0] Y_LAST = 5'(GRID_H - 1);

  state_e              state_q, state_d;
  logic                prev_draw_q;
  logic [5:0]          x_q, x_d;
  logic [4:0]          y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         stage_q, stage_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovr_q, ovr_d;

  logic boundary;
  logic last_cell;
  logic xfer;

  assign boundary  = prev_draw_q & ~isDrawing;
  assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);
  assign xfer      = cell_valid & cell_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (boundary) state_d = LATCH;
      LATCH:   state_d = SCAN;
      SCAN:    if (xfer && last_cell) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cell_valid = (state_q == SCAN);
    frame_busy = (state_q == SCAN);
    cell_last  = (state_q == SCAN) && last_cell;
`ifdef STAGE_FRAME_BORDER_EN
    cell_border = (state_q == SCAN) &&
                  ((x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST));
`endif
  end

  // Indices stay parked on the final cell after its transfer so they never leave the grid.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    count_d = count_q;
    ovr_d   = ovr_q | (boundary && (state_q != IDLE));
    if (state_q == LATCH) begin
      stage_d = rstage;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
    end else if (xfer && !last_cell) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 5'(1);
      end else begin
        x_d = x_q + 6'(1);
      end
    end
    if (state_q == DONE) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_draw_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      stage_q     <= '0;
      count_q     <= '0;
      ovr_q       <= 1'b0;
    end else begin
      prev_draw_q <= isDrawing;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      stage_q     <= stage_d;
      count_q     <= count_d;
      ovr_q       <= ovr_d;
    end
  end

  assign cell_x      = x_q;
  assign cell_y      = y_q;
  assign cell_addr   = addr_q;
  assign cell_stage  = stage_q;
  assign frame_count = count_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_stage_frame_reader.sv
// Scoreboard bench for stage_frame_reader: frame-level reference model pushes expected
// descriptors per accepted boundary; a negedge monitor pops and compares.
module tb_stage_frame_reader;

  localparam int GW    = 40;
  localparam int GH    = 30;
  localparam int NCELL = GW * GH;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rstage;
  logic        isDrawing;
  logic        cell_ready;
  logic        cell_valid;
  logic [10:0] cell_addr;
  logic [5:0]  cell_x;
  logic [4:0]  cell_y;
  logic [31:0] cell_stage;
  logic        cell_last;
  logic        frame_busy;
  logic [15:0] frame_count;
  logic        overrun;
`ifdef STAGE_FRAME_BORDER_EN
  logic        cell_border;
`endif

  stage_frame_reader #(.GRID_W(GW), .GRID_H(GH), .ADDR_W(11), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .rstage(rstage), .isDrawing(isDrawing),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_addr(cell_addr),
    .cell_x(cell_x), .cell_y(cell_y), .cell_stage(cell_stage), .cell_last(cell_last),
    .frame_busy(frame_busy), .frame_count(frame_count), .overrun(overrun)
`ifdef STAGE_FRAME_BORDER_EN
    , .cell_border(cell_border)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          addr;
    int          x;
    int          y;
    logic [31:0] stage;
  } cell_t;

  cell_t exp_q[$];
  cell_t e;
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  bit    mon_en      = 0;

  // Frame-level reference state
  bit m_prev = 0, m_busy = 0, m_latch_pend = 0, m_done_pend = 0, m_ovr = 0;
  bit m_last_xfer;
  bit bnd;
  int m_count = 0;
  int m_xfers = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (mon_en) begin
      m_last_xfer = 0;
      check("cell_valid", cell_valid, exp_q.size() != 0);
      check("frame_busy", frame_busy, exp_q.size() != 0);
      check("frame_count", frame_count, m_count);
      check("overrun", overrun, m_ovr);
      if (cell_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        check("cell_addr", cell_addr, e.addr);
        check("cell_x", cell_x, e.x);
        check("cell_y", cell_y, e.y);
        check("cell_stage", cell_stage, e.stage);
        check("cell_last", cell_last, e.addr == NCELL - 1);
`ifdef STAGE_FRAME_BORDER_EN
        check("cell_border", cell_border,
              (e.x == 0) || (e.x == GW - 1) || (e.y == 0) || (e.y == GH - 1));
`endif
        if (cell_ready) begin
          void'(exp_q.pop_front());
          m_xfers++;
          if (e.addr == NCELL - 1) m_last_xfer = 1;
        end
      end
      // Advance the reference by what happens at the coming clock edge
      bnd = m_prev & ~isDrawing;
      if (m_latch_pend) begin
        for (int i = 0; i < NCELL; i++)
          exp_q.push_back('{addr: i, x: i % GW, y: i / GW, stage: rstage});
        m_latch_pend = 0;
        m_xfers = 0;
      end
      if (bnd) begin
        if (m_busy) m_ovr = 1;
        else begin
          m_busy = 1;
          m_latch_pend = 1;
        end
      end
      if (m_done_pend) begin
        m_count = (m_count + 1) % 65536;
        m_busy = 0;
        m_done_pend = 0;
      end
      if (m_last_xfer) m_done_pend = 1;
      m_prev = isDrawing;
      if (reset) begin
        exp_q.delete();
        m_busy = 0; m_latch_pend = 0; m_done_pend = 0;
        m_ovr = 0; m_count = 0; m_prev = 0; m_xfers = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic make_boundary(input logic [31:0] stage, input int low_cycles);
    isDrawing = 1'b1;
    tick();
    isDrawing = 1'b0;
    rstage = stage;
    repeat (low_cycles) tick();
    isDrawing = 1'b1;
  endtask

  // mode: 0 ready high, 1 toggling, 2 random
  task automatic run_frame(input int mode, input int stage_at, input logic [31:0] new_stage,
                           input int bnd_at, input int rst_at, input int budget);
    int  n = 0;
    int  low = 0;
    bit  bnd_done = 0, rst_done = 0;
    while ((m_busy || exp_q.size() != 0) && n < budget) begin
      case (mode)
        0:       cell_ready = 1'b1;
        1:       cell_ready = (n % 2) == 1;
        default: cell_ready = ($urandom_range(3) != 0);
      endcase
      if (stage_at >= 0 && m_xfers >= stage_at) rstage = new_stage;
      if (low > 0) begin
        low--;
        if (low == 0) isDrawing = 1'b1;
      end else if (bnd_at >= 0 && !bnd_done && m_xfers >= bnd_at) begin
        isDrawing = 1'b0;
        low = 2;
        bnd_done = 1;
      end
      if (rst_at >= 0 && !rst_done && m_xfers >= rst_at) begin
        reset = 1'b1;
        rst_done = 1;
      end else reset = 1'b0;
      tick();
      n++;
    end
    reset = 1'b0;
    isDrawing = 1'b1;
    vectors++;
    if (m_busy || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_timeout: still busy after %0d cycles, required idle", budget);
    end
    repeat (3) tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; isDrawing = 1'b0; cell_ready = 1'b1; rstage = '0;
    tick();
    mon_en = 1;
    tick();
    reset = 1'b0;
    repeat (100) tick();
    isDrawing = 1'b1;
    repeat (5) tick();

    make_boundary(32'd2, 1);
    run_frame(0, -1, '0, -1, -1, 3000);

    make_boundary(32'd2, 4);
    run_frame(1, 200, 32'd5, -1, -1, 5000);
    make_boundary(32'd7, 1);
    rstage = 32'd5;
    run_frame(0, -1, '0, -1, -1, 3000);

    make_boundary(32'hA5A5_0001, 3);
    run_frame(0, -1, '0, 300, -1, 3000);
    repeat (20) tick();

    make_boundary(32'd9, 1);
    run_frame(0, -1, '0, -1, 500, 3000);
    make_boundary(32'd11, 2);
    run_frame(2, -1, '0, -1, -1, 6000);

    for (int c = 0; c < 6000; c++) begin
      cell_ready = ($urandom_range(3) != 0);
      rstage = $urandom;
      if ($urandom_range(299) == 0) isDrawing = ~isDrawing;
      tick();
    end
    isDrawing = 1'b1;
    run_frame(2, -1, '0, -1, -1, 6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
